lsu_mmio_hs: RTL and testbench

LSU_MMIO_HS -- requirements
Module: lsu_mmio_hs

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_lane_align.sv | 56 +++++
 rtl/lsu_mmio_hs.sv | 206 ++++++++++++++++++++
 tb/tb_lsu_mmio_hs.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the LSU MMIO handshake block: access sizes, IO region
// bases and the control FSM states.
package lsu_pkg;

    localparam logic [1:0]  OP_WORD  = 2'b00;
    localparam logic [1:0]  OP_HALF  = 2'b10;
    localparam logic [1:0]  OP_BYTE  = 2'b11;

    localparam logic [15:0] OUT_BASE = 16'h1000;
    localparam logic [15:0] IN_BASE  = 16'h1001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAM_RD = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte enables and lane replication, load
// lane extraction with sign/zero extension, and alignment checking.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [1:0]  addr_i,
    input  logic        ld_un_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Lane select and size-dependent steering
    always_comb begin
        half_s     = addr_i[1] ? rword_i[31:16] : rword_i[15:0];
        byte_s     = rword_i[7:0];
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rword_i;
        misalign_o = 1'b0;
        case (addr_i)
            2'd0:    byte_s = rword_i[7:0];
            2'd1:    byte_s = rword_i[15:8];
            2'd2:    byte_s = rword_i[23:16];
            default: byte_s = rword_i[31:24];
        endcase
        case (op_i)
            OP_HALF: begin
                be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = ld_un_i ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
                misalign_o = addr_i[0];
            end
            OP_BYTE: begin
                be_o       = 4'b0001 << addr_i;
                wdata_o    = {4{wdata_i[7:0]}};
                rdata_o    = ld_un_i ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
                misalign_o = 1'b0;
            end
            default: begin
                be_o       = 4'b1111;
                wdata_o    = wdata_i;
                rdata_o    = rword_i;
                misalign_o = (addr_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/lsu_mmio_hs.sv
// Load/store unit front end: decodes RAM / output-register / input-register
// regions behind a valid-ready request and a one-cycle ack.
module lsu_mmio_hs
    import lsu_pkg::*;
#(
    parameter int ADDRBIT = 14,
    parameter int NUM_OUT = 8,
    parameter int NUM_IN  = 2,
    parameter int RAM_LAT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req,
    output logic                  o_ready,
    input  logic                  i_we,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wdata,
    input  logic [1:0]            i_op,
    input  logic                  i_ld_un,
    output logic                  o_ack,
    output logic [31:0]           o_rdata,
    output logic                  o_fault,
    output logic [NUM_OUT*32-1:0] o_io_out,
    input  logic [NUM_IN*32-1:0]  i_io_in,
    output logic [ADDRBIT-3:0]    o_ram_addr,
    output logic                  o_ram_we,
    output logic [3:0]            o_ram_be,
    output logic [31:0]           o_ram_wdata,
    input  logic [31:0]           i_ram_rdata
);

    localparam logic [4:0] NUM_OUT_L = 5'(NUM_OUT);
    localparam logic [4:0] NUM_IN_L  = 5'(NUM_IN);
    localparam logic [2:0] LAT_LAST  = 3'(RAM_LAT - 1);

    lsu_state_e                  state_q, state_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic [ADDRBIT-1:0]          addr_q, addr_d;
    logic [31:0]                 wdata_q, wdata_d;
    logic [1:0]                  op_q, op_d;
    logic                        ld_un_q, ld_un_d;
    logic                        we_q, we_d;
    logic                        ram_q, ram_d;
    logic                        fault_q, fault_d;
    logic [31:0]                 rdata_q, rdata_d;
    logic [3:0]                  be_q, be_d;
    logic [NUM_OUT-1:0][31:0]    io_out_q, io_out_d;
    logic [NUM_IN-1:0][31:0]     sync1_q, sync2_q;

    logic        idle_s, accept_s, ram_hit_s, out_hit_s, in_hit_s, fault_s;
    logic [3:0]  idx_s;
    logic [31:0] io_word_s;
    logic [1:0]  la_op_s, la_addr_s;
    logic        la_un_s, la_misalign_s;
    logic [31:0] la_rword_s, la_wdata_s, la_rdata_s;
    logic [3:0]  la_be_s;

    // While idle the lane logic works on the live request, afterwards on the captured one
    assign idle_s     = (state_q == ST_IDLE);
    assign accept_s   = i_req & idle_s;
    assign la_op_s    = idle_s ? i_op : op_q;
    assign la_addr_s  = idle_s ? i_addr[1:0] : addr_q[1:0];
    assign la_un_s    = idle_s ? i_ld_un : ld_un_q;
    assign la_rword_s = idle_s ? io_word_s : i_ram_rdata;

    lsu_lane_align u_align (
        .op_i       (la_op_s),
        .addr_i     (la_addr_s),
        .ld_un_i    (la_un_s),
        .wdata_i    (i_wdata),
        .rword_i    (la_rword_s),
        .be_o       (la_be_s),
        .wdata_o    (la_wdata_s),
        .rdata_o    (la_rdata_s),
        .misalign_o (la_misalign_s)
    );

    // Region decode and IO read mux for the request on the bus
    always_comb begin
        idx_s     = i_addr[15:12];
        ram_hit_s = ((i_addr >> ADDRBIT) == 32'd0);
        out_hit_s = (i_addr[31:16] == OUT_BASE) && ({1'b0, idx_s} < NUM_OUT_L);
        in_hit_s  = (i_addr[31:16] == IN_BASE) && ({1'b0, idx_s} < NUM_IN_L);
        fault_s   = la_misalign_s | ~(ram_hit_s | out_hit_s | in_hit_s) | (in_hit_s & i_we);
        io_word_s = 32'd0;
        for (int k = 0; k < NUM_OUT; k++) begin
            io_word_s = (out_hit_s && idx_s == 4'(k)) ? io_out_q[k] : io_word_s;
        end
        for (int k = 0; k < NUM_IN; k++) begin
            io_word_s = (in_hit_s && idx_s == 4'(k)) ? sync2_q[k] : io_word_s;
        end
    end

    // FSM next state, request capture and output-register update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        op_d     = op_q;
        ld_un_d  = ld_un_q;
        we_d     = we_q;
        ram_d    = ram_q;
        fault_d  = fault_q;
        rdata_d  = rdata_q;
        be_d     = be_q;
        io_out_d = io_out_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_d  = i_addr[ADDRBIT-1:0];
                    wdata_d = la_wdata_s;
                    op_d    = i_op;
                    ld_un_d = i_ld_un;
                    we_d    = i_we;
                    ram_d   = ram_hit_s;
                    fault_d = fault_s;
                    cnt_d   = 3'd0;
                    be_d    = (ram_hit_s & i_we & ~fault_s) ? la_be_s : 4'b0000;
                    if (fault_s) begin
                        rdata_d = 32'd0;
                    end else if (i_we | ram_hit_s) begin
                        rdata_d = rdata_q;
                    end else begin
                        rdata_d = la_rdata_s;
                    end
                    for (int k = 0; k < NUM_OUT; k++) begin
                        for (int b = 0; b < 4; b++) begin
                            io_out_d[k][8*b +: 8] =
                                (out_hit_s && i_we && !fault_s && idx_s == 4'(k) && la_be_s[b])
                                ? la_wdata_s[8*b +: 8] : io_out_q[k][8*b +: 8];
                        end
                    end
                    state_d = (ram_hit_s & ~i_we & ~fault_s) ? ST_RAM_RD : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RAM_RD: begin
                if (cnt_q == LAT_LAST) begin
                    rdata_d = la_rdata_s;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = ST_RAM_RD;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            op_q     <= 2'b00;
            ld_un_q  <= 1'b0;
            we_q     <= 1'b0;
            ram_q    <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= 32'd0;
            be_q     <= 4'b0000;
            io_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            op_q     <= op_d;
            ld_un_q  <= ld_un_d;
            we_q     <= we_d;
            ram_q    <= ram_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
            be_q     <= be_d;
            io_out_q <= io_out_d;
        end
    end

    // Two-flop synchroniser for the asynchronous input words
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_io_in;
            sync2_q <= sync1_q;
        end
    end

    // RAM sees the live address at accept so read data lands RAM_LAT cycles later
    assign o_ram_addr  = idle_s ? i_addr[ADDRBIT-1:2] : addr_q[ADDRBIT-1:2];
    assign o_ram_we    = (state_q == ST_RESP) & we_q & ram_q & ~fault_q;
    assign o_ram_be    = be_q;
    assign o_ram_wdata = wdata_q;
    assign o_ready     = idle_s;
    assign o_ack       = (state_q == ST_RESP);
    assign o_rdata     = rdata_q;
    assign o_fault     = fault_q;
    assign o_io_out    = io_out_q;

endmodule

// File: tb/tb_lsu_mmio_hs.sv
// Directed bench for lsu_mmio_hs with a behavioural RAM of latency RAM_LAT.
module tb_lsu_mmio_hs;

    localparam int ADDRBIT = 14;
    localparam int NUM_OUT = 8;
    localparam int NUM_IN  = 2;
    localparam int RAM_LAT = 2;
    localparam logic [1:0] W = 2'b00;
    localparam logic [1:0] H = 2'b10;
    localparam logic [1:0] B = 2'b11;

    logic                  i_clk = 1'b0;
    logic                  i_reset = 1'b1;
    logic                  i_req = 1'b0;
    logic                  i_we = 1'b0;
    logic [31:0]           i_addr = 32'd0;
    logic [31:0]           i_wdata = 32'd0;
    logic [1:0]            i_op = 2'b00;
    logic                  i_ld_un = 1'b0;
    logic [NUM_IN*32-1:0]  i_io_in = '0;
    logic [31:0]           i_ram_rdata;
    logic                  o_ready, o_ack, o_fault, o_ram_we;
    logic [31:0]           o_rdata, o_ram_wdata;
    logic [NUM_OUT*32-1:0] o_io_out;
    logic [ADDRBIT-3:0]    o_ram_addr;
    logic [3:0]            o_ram_be;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt = 0;
    int we_cnt  = 0;
    logic [3:0]  last_be;
    logic [31:0] last_wd;
    logic [31:0] last_ra;

    always #5 i_clk = ~i_clk;

    lsu_mmio_hs #(.ADDRBIT(ADDRBIT), .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN), .RAM_LAT(RAM_LAT)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .o_ready(o_ready),
        .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_op(i_op), .i_ld_un(i_ld_un),
        .o_ack(o_ack), .o_rdata(o_rdata), .o_fault(o_fault), .o_io_out(o_io_out),
        .i_io_in(i_io_in), .o_ram_addr(o_ram_addr), .o_ram_we(o_ram_we),
        .o_ram_be(o_ram_be), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
    );

    // Behavioural synchronous RAM with byte-enabled writes and RAM_LAT read pipeline
    logic [31:0] mem [0:(1<<(ADDRBIT-2))-1];
    logic [31:0] rd_pipe [0:RAM_LAT-1];
    always @(posedge i_clk) begin
        if (o_ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (o_ram_be[b]) mem[o_ram_addr][8*b +: 8] <= o_ram_wdata[8*b +: 8];
            end
        end
        rd_pipe[0] <= mem[o_ram_addr];
        for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign i_ram_rdata = rd_pipe[RAM_LAT-1];

    always @(negedge i_clk) begin
        if (o_ack) ack_cnt++;
        if (o_ram_we) begin
            we_cnt++;
            last_be = o_ram_be;
            last_wd = o_ram_wdata;
            last_ra = 32'(o_ram_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request from an idle cycle and report the ack data and latency
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] op, input logic un,
                          output logic [31:0] rd, output logic flt, output int lat);
        bit got = 0;
        i_we = we; i_addr = addr; i_wdata = wd; i_op = op; i_ld_un = un; i_req = 1'b1;
        rd = 32'd0; flt = 1'b0; lat = -1;
        for (int w = 0; w < 20; w++) begin
            @(negedge i_clk);
            if (o_ready) begin got = 1; break; end
        end
        @(posedge i_clk); #1;
        i_req = 1'b0;
        if (!got) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else begin
            for (int c = 1; c <= 20; c++) begin
                @(negedge i_clk);
                if (o_ack) begin lat = c; rd = o_rdata; flt = o_fault; break; end
            end
            @(posedge i_clk); #1;
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  op;
        logic        un;
        logic        exp_f;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(string n, logic we, logic [31:0] a, logic [31:0] wd, logic [1:0] op,
                                logic un, logic f, logic c, logic [31:0] r, int l);
        vec_t v;
        v.name = n; v.we = we; v.addr = a; v.wdata = wd; v.op = op; v.un = un;
        v.exp_f = f; v.chk_rd = c; v.exp_rd = r; v.exp_lat = l;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin : main
        logic [31:0] rd;
        logic        flt;
        int          lat, n0, a0, n_acc;
        logic [31:0] b_addr [4];
        logic [31:0] b_wd [4];
        logic        b_we [4];

        vecs.push_back(mk("sw_ram",     1'b1, 32'h0000_0010, 32'h1122_3344, W, 1'b0, 1'b0, 1'b0, 32'h0,         1));
        vecs.push_back(mk("sw_out1",    1'b1, 32'h1000_1000, 32'hDEAD_BEEF, W, 1'b0, 1'b0, 1'b0, 32'h0,         1));
        vecs.push_back(mk("lw_out1",    1'b0, 32'h1000_1000, 32'h0,         W, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1));
        vecs.push_back(mk("sb_ram",     1'b1, 32'h0000_0013, 32'h0000_0080, B, 1'b0, 1'b0, 1'b0, 32'h0,         1));
        vecs.push_back(mk("lb_ram",     1'b0, 32'h0000_0013, 32'h0,         B, 1'b0, 1'b0, 1'b1, 32'hFFFF_FF80, 3));
        vecs.push_back(mk("lbu_ram",    1'b0, 32'h0000_0013, 32'h0,         B, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 3));
        vecs.push_back(mk("lh_ram",     1'b0, 32'h0000_0012, 32'h0,         H, 1'b0, 1'b0, 1'b1, 32'hFFFF_8022, 3));
        vecs.push_back(mk("lhu_ram",    1'b0, 32'h0000_0010, 32'h0,         H, 1'b1, 1'b0, 1'b1, 32'h0000_3344, 3));
        vecs.push_back(mk("lw_ram",     1'b0, 32'h0000_0010, 32'h0,         W, 1'b0, 1'b0, 1'b1, 32'h8022_3344, 3));
        vecs.push_back(mk("lh_misal",   1'b0, 32'h0000_0001, 32'h0,         H, 1'b0, 1'b1, 1'b1, 32'h0,         1));
        vecs.push_back(mk("sw_in_rgn",  1'b1, 32'h1001_0000, 32'hCAFE_F00D, W, 1'b0, 1'b1, 1'b1, 32'h0,         1));
        vecs.push_back(mk("lw_unmap",   1'b0, 32'h2000_0000, 32'h0,         W, 1'b0, 1'b1, 1'b1, 32'h0,         1));
        vecs.push_back(mk("sw_out_oor", 1'b1, 32'h1000_8000, 32'h1,         W, 1'b0, 1'b1, 1'b1, 32'h0,         1));
        vecs.push_back(mk("sw_misal",   1'b1, 32'h1000_0002, 32'h1,         W, 1'b0, 1'b1, 1'b1, 32'h0,         1));
        vecs.push_back(mk("sh_out2",    1'b1, 32'h1000_2002, 32'hAAAA_5555, H, 1'b0, 1'b0, 1'b0, 32'h0,         1));
        vecs.push_back(mk("sb_out2",    1'b1, 32'h1000_2001, 32'h1234_5677, B, 1'b0, 1'b0, 1'b0, 32'h0,         1));
        vecs.push_back(mk("lw_out2",    1'b0, 32'h1000_2000, 32'h0,         W, 1'b0, 1'b0, 1'b1, 32'h5555_7700, 1));
        vecs.push_back(mk("lb_out2",    1'b0, 32'h1000_2001, 32'h0,         B, 1'b0, 1'b0, 1'b1, 32'h0000_0077, 1));
        vecs.push_back(mk("lhu_out2",   1'b0, 32'h1000_2002, 32'h0,         H, 1'b1, 1'b0, 1'b1, 32'h0000_5555, 1));
        vecs.push_back(mk("lb_out1_s",  1'b0, 32'h1000_1003, 32'h0,         B, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFDE, 1));
        vecs.push_back(mk("lw_in1",     1'b0, 32'h1001_1000, 32'h0,         W, 1'b0, 1'b0, 1'b1, 32'h0,         1));
        vecs.push_back(mk("lw_in_oor",  1'b0, 32'h1001_2000, 32'h0,         W, 1'b0, 1'b1, 1'b1, 32'h0,         1));

        // Reset values
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_ack",   32'(o_ack), 32'd0);
        chk("rst_fault", 32'(o_fault), 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_ramwe", 32'(o_ram_we), 32'd0);
        chk("rst_rambe", 32'(o_ram_be), 32'd0);
        chk("rst_ioout", 32'(o_io_out != '0), 32'd0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(posedge i_clk); #1;

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].op, vecs[i].un, rd, flt, lat);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
            chk({vecs[i].name, "_fault"}, 32'(flt), 32'(vecs[i].exp_f));
            if (vecs[i].chk_rd) chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
        end
        chk("io_out1", o_io_out[63:32], 32'hDEAD_BEEF);
        chk("io_out2", o_io_out[95:64], 32'h5555_7700);
        chk("io_out0", o_io_out[31:0], 32'h0);

        // Faulting accesses must not strobe the RAM
        n0 = we_cnt;
        do_req(1'b0, 32'h0000_0001, 32'h0, H, 1'b0, rd, flt, lat);
        do_req(1'b1, 32'h0000_0002, 32'h5, W, 1'b0, rd, flt, lat);
        chk("fault_no_strobe", 32'(we_cnt - n0), 32'd0);

        // Store strobe shape: byte and half
        n0 = we_cnt;
        do_req(1'b1, 32'h0000_0013, 32'h0000_0080, B, 1'b0, rd, flt, lat);
        chk("sb_strobes", 32'(we_cnt - n0), 32'd1);
        chk("sb_be", 32'(last_be), 32'h8);
        chk("sb_wdata", last_wd, 32'h8080_8080);
        chk("sb_raddr", last_ra, 32'd4);
        n0 = we_cnt;
        do_req(1'b1, 32'h0000_0022, 32'h1234_BEEF, H, 1'b0, rd, flt, lat);
        chk("sh_strobes", 32'(we_cnt - n0), 32'd1);
        chk("sh_be", 32'(last_be), 32'hC);
        chk("sh_wdata", last_wd, 32'hBEEF_BEEF);
        chk("sh_raddr", last_ra, 32'd8);
        do_req(1'b0, 32'h0000_0020, 32'h0, W, 1'b0, rd, flt, lat);
        chk("lw_after_sh", rd[31:16], 32'h0000_BEEF);

        // Synchroniser: one cycle later sees the old word, three cycles later the new one
        i_io_in[31:0] = 32'h1234_5678;
        @(posedge i_clk); #1;
        do_req(1'b0, 32'h1001_0000, 32'h0, W, 1'b0, rd, flt, lat);
        chk("sync_early", rd, 32'h0);
        i_io_in[31:0] = 32'h0;
        repeat (5) @(posedge i_clk);
        #1;
        i_io_in[31:0] = 32'h1234_5678;
        repeat (3) @(posedge i_clk);
        #1;
        do_req(1'b0, 32'h1001_0000, 32'h0, W, 1'b0, rd, flt, lat);
        chk("sync_late", rd, 32'h1234_5678);

        // Reset while waiting on the RAM aborts the load
        a0 = ack_cnt; n0 = we_cnt;
        i_we = 1'b0; i_addr = 32'h0000_0010; i_op = W; i_req = 1'b1;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_abort_ack", 32'(ack_cnt - a0), 32'd0);
        chk("rst_abort_we", 32'(we_cnt - n0), 32'd0);
        chk("rst_abort_ready", 32'(o_ready), 32'd1);
        for (int k = 0; k < NUM_OUT; k++) chk($sformatf("rst_io_out%0d", k), o_io_out[32*k +: 32], 32'd0);
        @(posedge i_clk); #1;

        // Back-to-back requests with i_req held high
        b_addr[0] = 32'h1000_3000; b_wd[0] = 32'h0303_0303; b_we[0] = 1'b1;
        b_addr[1] = 32'h1000_4000; b_wd[1] = 32'h0404_0404; b_we[1] = 1'b1;
        b_addr[2] = 32'h0000_0010; b_wd[2] = 32'h0;         b_we[2] = 1'b0;
        b_addr[3] = 32'h1000_5000; b_wd[3] = 32'h0505_0505; b_we[3] = 1'b1;
        a0 = ack_cnt; n_acc = 0;
        i_op = W; i_ld_un = 1'b0;
        i_we = b_we[0]; i_addr = b_addr[0]; i_wdata = b_wd[0]; i_req = 1'b1;
        for (int c = 0; c < 60 && n_acc < 4; c++) begin
            logic rdy;
            @(negedge i_clk);
            rdy = o_ready;
            @(posedge i_clk); #1;
            if (rdy) begin
                n_acc++;
                if (n_acc < 4) begin
                    i_we = b_we[n_acc]; i_addr = b_addr[n_acc]; i_wdata = b_wd[n_acc];
                end else begin
                    i_req = 1'b0;
                end
            end
        end
        i_req = 1'b0;
        repeat (8) @(posedge i_clk);
        @(negedge i_clk);
        chk("b2b_accepts", 32'(n_acc), 32'd4);
        chk("b2b_acks", 32'(ack_cnt - a0), 32'd4);
        chk("b2b_reg3", o_io_out[127:96], 32'h0303_0303);
        chk("b2b_reg4", o_io_out[159:128], 32'h0404_0404);
        chk("b2b_reg5", o_io_out[191:160], 32'h0505_0505);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
